// File: rtl/hilo_seq_unit.sv
// HI/LO register pair and MULT/DIV sequencer for the combinational mul_div_unit.
// Optional macro HILO_FWD_EN bypasses md_outH/md_outL onto hi/lo in the final RUN cycle.
module hilo_seq_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    input  logic [31:0] md_outH,
    input  logic [31:0] md_outL,
    output logic [31:0] md_inA,
    output logic [31:0] md_inB,
    output logic        md_sel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_zero
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = ($clog2(MAX_LAT + 1) > 6) ? $clog2(MAX_LAT + 1) : 6;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;
    logic          lastCycle;

    always_comb begin
        lastCycle = (state == RUN) && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            md_inA   <= '0;
            md_inB   <= '0;
            md_sel   <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        md_inA <= op_a;
                        md_inB <= op_b;
                        md_sel <= op_div;
                        // Divide by zero commits immediately without ever occupying the unit
                        if (op_div && (op_b == '0)) begin
                            hiReg    <= op_a;
                            loReg    <= '1;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            cnt   <= op_div ? DIV_CNT : MUL_CNT;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        if (mthi_we) hiReg <= mt_data;
                        if (mtlo_we) loReg <= mt_data;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        hiReg <= md_outH;
                        loReg <= md_outL;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HILO_FWD_EN
    always_comb begin
        hi    = lastCycle ? md_outH : hiReg;
        lo    = lastCycle ? md_outL : loReg;
        stall = busy & ((mf_req & ~lastCycle) | op_valid | mthi_we | mtlo_we);
    end
`else
    always_comb begin
        hi    = hiReg;
        lo    = loReg;
        stall = busy & (mf_req | op_valid | mthi_we | mtlo_we) & (lastCycle | ~lastCycle);
    end
`endif

endmodule

// File: tb/tb_hilo_seq_unit.sv
// Scoreboard bench for hilo_seq_unit with a behavioural mul_div_unit stand-in.
module tb_hilo_seq_unit;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0, op_div = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        mthi_we = 1'b0, mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mf_req = 1'b0;
    logic [31:0] md_outH, md_outL, md_inA, md_inB, hi, lo;
    logic        md_sel, busy, stall, done, div_zero;

    hilo_seq_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_div(op_div),
        .op_a(op_a), .op_b(op_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .mt_data(mt_data), .mf_req(mf_req), .md_outH(md_outH), .md_outL(md_outL),
        .md_inA(md_inA), .md_inB(md_inB), .md_sel(md_sel), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // External combinational multiplier/divider
    logic [63:0] prod;
    always_comb begin
        prod = {32'd0, md_inA} * {32'd0, md_inB};
        if (md_sel) begin
            md_outH = (md_inB == 0) ? 32'd0 : md_inA % md_inB;
            md_outL = (md_inB == 0) ? 32'd0 : md_inA / md_inB;
        end else begin
            md_outH = prod[63:32];
            md_outL = prod[31:0];
        end
    end

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          remain = 0;
    logic [31:0] refHi = '0, refLo = '0, pendH = '0, pendL = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check combinational view against the model, then advance the model.
    task automatic step(input logic ov, input logic dv, input logic [31:0] a, input logic [31:0] b,
                        input logic mth, input logic mtl, input logic [31:0] d, input logic mf);
        logic last;
        logic [63:0] p;
        @(negedge clk);
        op_valid = ov; op_div = dv; op_a = a; op_b = b;
        mthi_we = mth; mtlo_we = mtl; mt_data = d; mf_req = mf;
        #1;
        last = (remain == 1);
        chk("busy", {31'd0, busy}, {31'd0, remain > 0});
        chk("stall", {31'd0, stall},
            {31'd0, (remain > 0) && ((mf && !(FWD && last)) || ov || mth || mtl)});
        chk("hi", hi, (FWD && last) ? pendH : refHi);
        chk("lo", lo, (FWD && last) ? pendL : refLo);
        @(posedge clk);
        if (remain == 0) begin
            if (ov) begin
                if (dv && b == 0) begin
                    refHi = a;
                    refLo = 32'hFFFF_FFFF;
                    sb.push_back('{h: a, l: 32'hFFFF_FFFF, dz: 1'b1});
                end else begin
                    if (dv) begin
                        pendH = a % b;
                        pendL = a / b;
                        remain = DIV_LAT;
                    end else begin
                        p = {32'd0, a} * {32'd0, b};
                        pendH = p[63:32];
                        pendL = p[31:0];
                        remain = MUL_LAT;
                    end
                    sb.push_back('{h: pendH, l: pendL, dz: 1'b0});
                end
            end else begin
                if (mth) refHi = d;
                if (mtl) refLo = d;
            end
        end else begin
            remain--;
            if (remain == 0) begin
                refHi = pendH;
                refLo = pendL;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        op_valid = 0; mthi_we = 0; mtlo_we = 0; mf_req = 0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_dz", {31'd0, div_zero}, 0);
        chk("rst_inA", md_inA, 0);
        chk("rst_sel", {31'd0, md_sel}, 0);
        sb.delete();
        remain = 0;
        refHi = 0; refLo = 0; pendH = 0; pendL = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("commit_hi", hi, e.h);
                    chk("commit_lo", lo, e.l);
                    chk("commit_dz", {31'd0, div_zero}, {31'd0, e.dz});
                end
            end else if (rst_n && div_zero) begin
                chk("dz_without_done", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a, b, hiBefore;
        int r;
        applyReset();

        // MULT 7*6
        step(1, 0, 7, 6, 0, 0, 0, 0);
        idle(MUL_LAT + 1);
        chk("mul_lo42", lo, 42);
        chk("mul_hi0", hi, 0);

        // DIV 100/7 with MFHI held from cycle 3 until the result lands
        step(1, 1, 100, 7, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < DIV_LAT; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("div_lo14", lo, 14);
        chk("div_hi2", hi, 2);

        // Divide by zero
        step(1, 1, 32'h55, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'hFFFF_FFFF);

        // MTHI while busy is dropped, in IDLE it lands
        step(1, 0, 3, 5, 0, 0, 0, 0);
        hiBefore = pendH;
        step(0, 0, 0, 0, 1, 0, 32'hAAAA, 0);
        idle(MUL_LAT);
        chk("mthi_busy_dropped", hi, hiBefore);
        step(0, 0, 0, 0, 1, 0, 32'hAAAA, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mthi_idle", hi, 32'hAAAA);

        // MFLO on the final cycle of a multiply
        step(1, 0, 32'h1234_5678, 32'h9, 0, 0, 0, 0);
        idle(MUL_LAT - 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Reset with a divide in flight
        step(1, 1, 32'hDEAD_BEEF, 3, 0, 0, 0, 0);
        idle(3);
        applyReset();
        idle(DIV_LAT + 4);
        chk("post_reset_hi", hi, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(1, 300));
            step(r < 2, $urandom_range(0, 1) != 0, a, b,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom,
                 $urandom_range(0, 2) == 0);
        end
        idle(DIV_LAT + 4);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
